// File: rtl/dsc_pkg.sv
// Shared definitions for the deterministic stochastic-computing multiplier
// controller: default operand width, controller state encoding and the
// helper that sizes the run counter.
package dsc_pkg;

    localparam int SNG_WIDTH_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RESP  = 3'd4
    } dsc_ctrl_state_t;

    // One extra bit so the counter can hold RUN_CYCLES itself without wrapping.
    function automatic int cnt_width(input int run_cycles);
        return $clog2(run_cycles) + 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(2 ** (2 * SNG_WIDTH_DEF));

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter.
// Ports:
//   valid0, valid1 : request lines
//   last_id        : id of the requester served most recently
//   gnt            : one-hot grant (bit N = requester N), zero when no request
//   gnt_id         : index of the granted requester (0 when nothing is granted)
module rr_arb2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_id,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    always_comb begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
        if (valid0 && valid1) begin
            // Contention: favour whoever was not served last.
            gnt_id = ~last_id;
            gnt    = last_id ? 2'b01 : 2'b10;
        end else if (valid0) begin
            gnt    = 2'b01;
            gnt_id = 1'b0;
        end else if (valid1) begin
            gnt    = 2'b10;
            gnt_id = 1'b1;
        end
    end

endmodule

// File: rtl/dsc_mul_ctrl.sv
// Controller and two-requester arbiter for one deterministic stochastic
// multiplier datapath. Accepts operand pairs over valid/ready, runs the
// datapath for exactly RUN_CYCLES enabled cycles and returns the product
// with the requester id.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   reqN_valid/a/b, reqN_ready     : operand channels for requesters 0 and 1
//   rsp_valid/ready, rsp_z, rsp_id : result channel
//   mul_rst, mul_en, mul_a, mul_b  : datapath controls and operands
//   mul_z, mul_ov                  : datapath product count and B-SNG overflow
//   busy                           : controller not in IDLE
//   err                            : sticky, a job finished without any overflow pulse
//
// state | meaning
// IDLE  | arbitrate, accept one operand pair
// CLEAR | reset datapath and run counter (1 cycle)
// RUN   | datapath enabled for RUN_CYCLES cycles
// DRAIN | capture product and error status (1 cycle)
// RESP  | present result until accepted
module dsc_mul_ctrl
    import dsc_pkg::*;
#(
    parameter int SNG_WIDTH  = SNG_WIDTH_DEF,
    parameter int RUN_CYCLES = 2 ** (2 * SNG_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    input  logic [SNG_WIDTH-1:0]   req0_a,
    input  logic [SNG_WIDTH-1:0]   req0_b,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [SNG_WIDTH-1:0]   req1_a,
    input  logic [SNG_WIDTH-1:0]   req1_b,
    output logic                   req1_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2*SNG_WIDTH-1:0] rsp_z,
    output logic                   rsp_id,
    output logic                   mul_rst,
    output logic                   mul_en,
    output logic [SNG_WIDTH-1:0]   mul_a,
    output logic [SNG_WIDTH-1:0]   mul_b,
    input  logic [2*SNG_WIDTH-1:0] mul_z,
    input  logic                   mul_ov,
    output logic                   busy,
    output logic                   err
);

    localparam int               CNT_W    = cnt_width(RUN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    dsc_ctrl_state_t        state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ov_seen_q, ov_seen_d;
    logic                   op_id_q, op_id_d;
    logic                   last_id_q, last_id_d;
    logic [SNG_WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [SNG_WIDTH-1:0]   mul_b_q, mul_b_d;
    logic [2*SNG_WIDTH-1:0] rsp_z_q, rsp_z_d;
    logic                   rsp_id_q, rsp_id_d;
    logic                   err_q, err_d;

    logic [1:0]             gnt;
    logic                   gnt_id;

    rr_arb2 u_arb (
        .valid0  (req0_valid),
        .valid1  (req1_valid),
        .last_id (last_id_q),
        .gnt     (gnt),
        .gnt_id  (gnt_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ov_seen_q <= 1'b0;
            op_id_q   <= 1'b0;
            last_id_q <= 1'b1;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            rsp_z_q   <= '0;
            rsp_id_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ov_seen_q <= ov_seen_d;
            op_id_q   <= op_id_d;
            last_id_q <= last_id_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            rsp_z_q   <= rsp_z_d;
            rsp_id_q  <= rsp_id_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ov_seen_d  = ov_seen_q;
        op_id_d    = op_id_q;
        last_id_d  = last_id_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        rsp_z_d    = rsp_z_q;
        rsp_id_d   = rsp_id_q;
        err_d      = err_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        mul_en     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                req0_ready = gnt[0];
                req1_ready = gnt[1];
                // A grant only exists for a valid requester, so any grant is a handshake.
                if (gnt != 2'b00) begin
                    mul_a_d   = gnt_id ? req1_a : req0_a;
                    mul_b_d   = gnt_id ? req1_b : req0_b;
                    op_id_d   = gnt_id;
                    last_id_d = gnt_id;
                    state_d   = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_d     = '0;
                ov_seen_d = 1'b0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                mul_en = 1'b1;
                cnt_d  = cnt_q + CNT_ONE;
                if (mul_ov) begin
                    ov_seen_d = 1'b1;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Datapath counter has absorbed the last enabled cycle by now.
                rsp_z_d  = mul_z;
                rsp_id_d = op_id_q;
                err_d    = err_q | ~ov_seen_q;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Combinational so the datapath is cleared in the same cycles the controller is.
    assign mul_rst = rst | (state_q == ST_CLEAR);
    assign busy    = (state_q != ST_IDLE);
    assign mul_a   = mul_a_q;
    assign mul_b   = mul_b_q;
    assign rsp_z   = rsp_z_q;
    assign rsp_id  = rsp_id_q;
    assign err     = err_q;

endmodule
